dmem_access_ctrl: RTL

- Sequences every data-memory access issued by the MEM stage.
- Accepts the qualified load/store controls from the EX/MEM register and drives a req/ack data-memory port with word address, byte enables and lane-replicated store data.
- Stalls the pipeline until the access completes, then presents the aligned, sign- or zero-extended load value to the MEM/WB path.
- Detects illegal accesses and memory timeouts.

---
 rtl/dmem_access_ctrl_pkg.sv | 54 +++++
 rtl/dmem_access_ctrl_load_align.sv | 55 +++++
 rtl/dmem_access_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dlx_mem_pkg
//  Description : Shared definitions for the MEM-stage data-memory sequencer:
//                access-size encodings, controller state type, byte-enable
//                patterns and the alignment/legality helper.
//  Revision    : 1.0  initial release
// ============================================================================
//  Bit numbering note: all 32-bit vectors in this block are declared [31:0].
//  Architectural bit 0 (the most significant bit) is RTL bit 31, so byte
//  lane 0 (address offset 0, big-endian) lives in RTL bits [31:24], and
//  byte-enable bit be[0] (lane 0) is RTL bit 3.
// ============================================================================
package dlx_mem_pkg;

  // Access-size encodings carried on dsize
  localparam logic [1:0] DS_BYTE = 2'b00;
  localparam logic [1:0] DS_HALF = 2'b01;
  localparam logic [1:0] DS_WORD = 2'b10;
  localparam logic [1:0] DS_ILL  = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte-enable patterns (MSB = lane 0)
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_LANE0   = 4'b1000;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // An access is legal when it is not simultaneously a read and a write,
  // uses a defined size, and is naturally aligned for that size.
  function automatic logic access_legal(input logic       rd,
                                        input logic       wr,
                                        input logic [1:0] dsize,
                                        input logic [1:0] offset);
    logic ok;
    ok = !(rd && wr);
    case (dsize)
      DS_BYTE: ok = ok;
      DS_HALF: ok = ok && !offset[0];
      DS_WORD: ok = ok && (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_ctrl_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load-data aligner. Selects the addressed
//                byte/halfword lane of a big-endian memory word, moves it to
//                the low end of the result and sign- or zero-extends it.
//                Words pass through unchanged.
//  Revision    : 1.0  initial release
// ============================================================================
//  Ports:
//    rdata  [31:0] in   raw memory word (lane 0 in [31:24])
//    dsize  [1:0]  in   DS_BYTE / DS_HALF / DS_WORD (DS_ILL yields 0)
//    offset [1:0]  in   byte offset within the word
//    sign          in   1 = sign-extend sub-word values
//    result [31:0] out  aligned, extended value
// ============================================================================
module load_align
  import dlx_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  dsize,
  input  logic [1:0]  offset,
  input  logic        sign,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    half_v = 16'h0000;
    result = 32'h0000_0000;

    case (offset)
      2'd0:    byte_v = rdata[31:24];
      2'd1:    byte_v = rdata[23:16];
      2'd2:    byte_v = rdata[15:8];
      default: byte_v = rdata[7:0];
    endcase

    // Halfwords are only ever at offset 0 or 2, so offset[1] picks the pair
    half_v = offset[1] ? rdata[15:0] : rdata[31:16];

    case (dsize)
      DS_BYTE: result = {{24{sign & byte_v[7]}}, byte_v};
      DS_HALF: result = {{16{sign & half_v[15]}}, half_v};
      DS_WORD: result = rdata;
      DS_ILL:  result = 32'h0000_0000;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_ctrl
//  Description : MEM-stage data-memory access sequencer. Accepts load/store
//                controls, drives a req/ack memory port with word address,
//                byte enables and lane-replicated store data, stalls the
//                pipeline until completion and returns aligned load data.
//                Flags illegal accesses and memory timeouts on err_out.
//  Revision    : 1.0  initial release
// ============================================================================
//  Ports:
//    clk            in   rising-edge clock
//    reset          in   asynchronous active-low reset
//    mem_read_in    in   load requested
//    mem_write_in   in   store requested
//    dsize_in [1:0] in   00 byte, 01 half, 10 word, 11 illegal
//    load_sign_in   in   sign-extend sub-word loads
//    addr_in  [31:0]      byte address
//    store_data_in[31:0]  store operand, sub-word data right-justified
//    dmem_req       out  memory request (REQ state only)
//    dmem_we        out  write strobe qualifier
//    dmem_addr[31:0]out  word-aligned address
//    dmem_be  [3:0] out  byte enables, bit 3 = lane 0 (MSB byte)
//    dmem_wdata[31:0]out lane-replicated store data
//    dmem_ack       in   access complete, rdata valid same cycle
//    dmem_rdata[31:0]in  read data
//    load_data_out[31:0]out registered aligned load value
//    stall_out      out  pipeline freeze
//    err_out        out  one-cycle error pulse
//  Vectors are [31:0] with RTL bit 31 = architectural bit 0 (big-endian).
// ============================================================================
module dmem_access_ctrl
  import dlx_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  dsize_in,
  input  logic        load_sign_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data_out,
  output logic        stall_out,
  output logic        err_out
);

  // Last counter value before an unanswered request is abandoned
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        dsize_q, dsize_d;
  logic              sign_q, sign_d;
  logic [1:0]        off_q, off_d;
  logic [29:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              to_q, to_d;

  logic              acc;
  logic              legal;
  logic [31:0]       aligned;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;

  assign acc   = mem_read_in | mem_write_in;
  assign legal = access_legal(mem_read_in, mem_write_in, dsize_in, addr_in[1:0]);

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .dsize  (dsize_q),
    .offset (off_q),
    .sign   (sign_q),
    .result (aligned)
  );

  // Store lane mapping computed at accept time and held through REQ
  always_comb begin
    be_new    = BE_NONE;
    wdata_new = store_data_in;
    case (dsize_in)
      DS_BYTE: begin
        be_new    = BE_LANE0 >> addr_in[1:0];
        wdata_new = {4{store_data_in[7:0]}};
      end
      DS_HALF: begin
        be_new    = addr_in[1] ? BE_HALF_LO : BE_HALF_HI;
        wdata_new = {2{store_data_in[15:0]}};
      end
      DS_WORD: begin
        be_new    = BE_WORD;
        wdata_new = store_data_in;
      end
      default: begin
        be_new    = BE_NONE;
        wdata_new = store_data_in;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    dsize_d     = dsize_q;
    sign_d      = sign_q;
    off_d       = off_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    to_d        = to_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        to_d  = 1'b0;
        if (acc && legal) begin
          we_d    = mem_write_in;
          dsize_d = dsize_in;
          sign_d  = load_sign_in;
          off_d   = addr_in[1:0];
          addr_d  = addr_in[31:2];
          be_d    = be_new;
          wdata_d = wdata_new;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          if (!we_q) begin
            load_data_d = aligned;
          end
          state_d = ST_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          load_data_d = 32'h0000_0000;
          to_d        = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // Unconditional return: the instruction still on the inputs this
        // cycle has already been serviced and must not be re-issued.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      dsize_q     <= DS_BYTE;
      sign_q      <= 1'b0;
      off_q       <= 2'b00;
      addr_q      <= '0;
      be_q        <= BE_NONE;
      wdata_q     <= '0;
      load_data_q <= '0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      dsize_q     <= dsize_d;
      sign_q      <= sign_d;
      off_q       <= off_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      to_q        <= to_d;
    end
  end

  assign dmem_req      = (state_q == ST_REQ);
  assign dmem_we       = (state_q == ST_REQ) & we_q;
  assign dmem_addr     = {addr_q, 2'b00};
  assign dmem_be       = (state_q == ST_REQ) ? be_q : BE_NONE;
  assign dmem_wdata    = wdata_q;
  assign load_data_out = load_data_q;

  // Gated by reset so both outputs read 0 while reset is held, even though
  // the IDLE term is combinational from the pipeline inputs.
  assign stall_out = reset & (((state_q == ST_IDLE) & acc & legal) |
                              (state_q == ST_REQ));
  assign err_out   = reset & (((state_q == ST_IDLE) & acc & ~legal) |
                              ((state_q == ST_DONE) & to_q));

endmodule
`default_nettype wire
